// File: rtl/reverb_template_nios2_cpu_debug_mem_access_pkg.sv
// Shared definitions for the Nios II debug-memory access stage.
// Holds the FSM state encoding, the field positions inside the 38-bit
// JTAG data word (jdo), and the encoding of the one-entry pending
// JTAG request kind.
package reverb_template_nios2_cpu_debug_mem_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // port free: serve pending JTAG first, else CPU
        ST_J_RD = 2'd1,   // JTAG read issued, RAM q valid this cycle
        ST_C_RD = 2'd2    // CPU read issued, RAM q valid this cycle
    } state_t;

    typedef enum logic {
        PEND_RD = 1'b0,
        PEND_WR = 1'b1
    } pend_kind_t;

    // jdo field positions
    localparam int JDO_ADDR_LSB   = 2;
    localparam int JDO_DATA_LSB   = 3;
    localparam int JDO_DATA_MSB   = 34;
    localparam int JDO_RD_BIT     = 35;
    localparam int JDO_ERRCLR_BIT = 36;

endpackage

// File: rtl/reverb_template_nios2_cpu_debug_mem_access_if.sv
// Avalon-MM debug slave bundle between the CPU and the debug-memory
// access stage.
//   master modport : CPU side (drives address/read/write/data/byteenable/
//                    debugaccess, receives readdata/waitrequest)
//   slave modport  : debug-memory side (the reverse)
interface reverb_template_nios2_cpu_debug_mem_access_if #(
    parameter int ADDR_W = 8
) ();
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [3:0]        avs_byteenable;
    logic              avs_debugaccess;
    logic [31:0]       avs_readdata;
    logic              avs_waitrequest;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
               avs_byteenable, avs_debugaccess,
        input  avs_readdata, avs_waitrequest
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
               avs_byteenable, avs_debugaccess,
        output avs_readdata, avs_waitrequest
    );
endinterface

// File: rtl/reverb_template_nios2_cpu_debug_mem_ram.sv
// Single-port debug RAM, 2^ADDR_W x 32-bit words, byte-writable,
// one-cycle registered read (read-before-write on the same address).
// No reset: contents survive a system reset.
//   clk     : clock
//   i_we    : write enable
//   i_be    : byte enables, qualify i_we per byte lane
//   i_addr  : word address
//   i_wdata : write data
//   o_q     : registered read data for the address of the previous cycle
module reverb_template_nios2_cpu_debug_mem_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [3:0]        i_be,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_q
);
    localparam int DEPTH = 1 << ADDR_W;

    // One byte-wide array per lane keeps each lane a plain inferable RAM.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi = gi + 1) begin : g_lane
            logic [7:0] r_mem [DEPTH];
            logic [7:0] r_q;

            always_ff @(posedge clk) begin
                if (i_we && i_be[gi]) begin
                    r_mem[i_addr] <= i_wdata[gi*8 +: 8];
                end
                r_q <= r_mem[i_addr];
            end

            assign o_q[gi*8 +: 8] = r_q;
        end
    endgenerate
endmodule

// File: rtl/reverb_template_nios2_cpu_debug_mem_access.sv
// Debug-memory access stage behind the Nios II JTAG debug front end.
// Captures JTAG ocimem strobes into a one-entry pending request and
// arbitrates them (with priority) against CPU Avalon accesses on the
// single port of the debug RAM.
//   clk, reset_n             : clock, asynchronous active-low reset
//   jdo                      : JTAG data word, valid with the strobes
//   take_action_ocimem_a     : load address; optional read / error clear
//   take_action_ocimem_b     : write jdo data, post-increment address
//   take_no_action_ocimem_a  : read, post-increment address
//   avs                      : CPU Avalon debug slave (slave modport)
//   MonDReg                  : last JTAG read data
//   monitor_ready            : last JTAG request completed
//   monitor_error            : sticky overrun/collision flag
module reverb_template_nios2_cpu_debug_mem_access
    import reverb_template_nios2_cpu_debug_mem_access_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic        take_no_action_ocimem_a,
    reverb_template_nios2_cpu_debug_mem_access_if.slave avs,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        monitor_error
);
    state_t            r_state, w_state_next;
    logic              r_pend_valid;
    pend_kind_t        r_pend_kind;
    logic [ADDR_W-1:0] r_pend_addr;
    logic [31:0]       r_pend_data;
    logic              r_pend_inc;      // read came from no_action_a
    logic [ADDR_W-1:0] r_jaddr;
    logic [31:0]       r_mon_dreg;
    logic [31:0]       r_avs_readdata;
    logic              r_mon_ready;
    logic              r_mon_error;

    logic              w_ram_we;
    logic [3:0]        w_ram_be;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [31:0]       w_ram_wdata;
    logic [31:0]       w_ram_q;
    logic              w_jtag_wr_done;
    logic              w_jtag_rd_issue;
    logic              w_cpu_done;
    logic              w_busy;
    logic              w_any_strobe;
    logic              w_multi_strobe;
    logic [ADDR_W-1:0] w_jdo_addr;
    logic              w_unused;

    assign w_jdo_addr     = jdo[JDO_ADDR_LSB +: ADDR_W];
    assign w_unused       = ^{jdo[37], jdo[1:0]};
    // A request is outstanding until its J_RD cycle (or write) retires.
    assign w_busy         = r_pend_valid | (r_state == ST_J_RD);
    assign w_any_strobe   = take_action_ocimem_a | take_action_ocimem_b |
                            take_no_action_ocimem_a;
    assign w_multi_strobe = (take_action_ocimem_a & take_action_ocimem_b) |
                            (take_action_ocimem_a & take_no_action_ocimem_a) |
                            (take_action_ocimem_b & take_no_action_ocimem_a);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_ram_we        = 1'b0;
        w_ram_be        = avs.avs_byteenable;
        w_ram_addr      = avs.avs_address;
        w_ram_wdata     = avs.avs_writedata;
        w_jtag_wr_done  = 1'b0;
        w_jtag_rd_issue = 1'b0;
        w_cpu_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pend_valid) begin
                    w_ram_addr = r_pend_addr;
                    if (r_pend_kind == PEND_WR) begin
                        w_ram_we       = 1'b1;
                        w_ram_be       = 4'hF;
                        w_ram_wdata    = r_pend_data;
                        w_jtag_wr_done = 1'b1;
                    end else begin
                        w_jtag_rd_issue = 1'b1;
                        w_state_next    = ST_J_RD;
                    end
                end else if (avs.avs_write) begin
                    // Non-debug writes are accepted but have no effect.
                    w_ram_we   = avs.avs_debugaccess;
                    w_cpu_done = 1'b1;
                end else if (avs.avs_read) begin
                    w_state_next = ST_C_RD;
                end
            end
            ST_J_RD: w_state_next = ST_IDLE;
            ST_C_RD: begin
                w_state_next = ST_IDLE;
                w_cpu_done   = 1'b1;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_valid   <= 1'b0;
            r_pend_kind    <= PEND_RD;
            r_pend_addr    <= '0;
            r_pend_data    <= '0;
            r_pend_inc     <= 1'b0;
            r_jaddr        <= '0;
            r_mon_dreg     <= '0;
            r_avs_readdata <= '0;
            r_mon_ready    <= 1'b0;
            r_mon_error    <= 1'b0;
        end else begin
            if (r_state == ST_J_RD) begin
                r_mon_dreg  <= w_ram_q;
                r_mon_ready <= 1'b1;
                if (r_pend_inc) begin
                    r_jaddr <= r_pend_addr + 1'b1;
                end
            end
            if (r_state == ST_C_RD) begin
                r_avs_readdata <= w_ram_q;
            end
            if (w_jtag_wr_done) begin
                r_jaddr     <= r_pend_addr + 1'b1;
                r_mon_ready <= 1'b1;
            end
            if (w_jtag_wr_done || w_jtag_rd_issue) begin
                r_pend_valid <= 1'b0;
            end
            // Strobe capture. Accepted strobes can only arrive while the
            // port is free of JTAG work, so they never collide with the
            // completion updates above.
            if (w_any_strobe) begin
                if (w_busy) begin
                    r_mon_error <= 1'b1;
                end else begin
                    if (w_multi_strobe) begin
                        r_mon_error <= 1'b1;
                    end else if (take_action_ocimem_a && jdo[JDO_ERRCLR_BIT]) begin
                        r_mon_error <= 1'b0;
                    end
                    if (take_action_ocimem_a) begin
                        r_jaddr <= w_jdo_addr;
                        if (jdo[JDO_RD_BIT]) begin
                            r_pend_valid <= 1'b1;
                            r_pend_kind  <= PEND_RD;
                            r_pend_addr  <= w_jdo_addr;
                            r_pend_inc   <= 1'b0;
                            r_mon_ready  <= 1'b0;
                        end
                    end else if (take_action_ocimem_b) begin
                        r_pend_valid <= 1'b1;
                        r_pend_kind  <= PEND_WR;
                        r_pend_addr  <= r_jaddr;
                        r_pend_data  <= jdo[JDO_DATA_MSB:JDO_DATA_LSB];
                        r_pend_inc   <= 1'b1;
                        r_mon_ready  <= 1'b0;
                    end else begin
                        r_pend_valid <= 1'b1;
                        r_pend_kind  <= PEND_RD;
                        r_pend_addr  <= r_jaddr;
                        r_pend_inc   <= 1'b1;
                        r_mon_ready  <= 1'b0;
                    end
                end
            end
        end
    end

    reverb_template_nios2_cpu_debug_mem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_be    (w_ram_be),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_q     (w_ram_q)
    );

    assign avs.avs_waitrequest = (avs.avs_read | avs.avs_write) & ~w_cpu_done;
    assign avs.avs_readdata    = r_avs_readdata;
    assign MonDReg             = r_mon_dreg;
    assign monitor_ready       = r_mon_ready;
    assign monitor_error       = r_mon_error;

endmodule

// File: doc/reverb_template_nios2_cpu_debug_mem_access.md
# reverb_template_nios2_cpu_debug_mem_access

Debug-memory access stage directly downstream of the Nios II debug-slave JTAG front end. It consumes the system-clock-domain `jdo` word and `take_*_ocimem_*` strobes, and services JTAG reads/writes on a small on-chip debug RAM that is shared with the CPU's Avalon debug slave. It returns `MonDReg`, `monitor_ready` and `monitor_error` to the front end. JTAG requests are arbitrated against CPU accesses on a single RAM port.

## Interface
- `ADDR_W`, default 8: word-address width; the RAM holds 2^ADDR_W × 32-bit words.
- `clk` in 1: system clock; the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `jdo` in 38: JTAG data word, valid while any strobe is high.
- `take_action_ocimem_a` in 1: one-cycle strobe.
  - Loads the JTAG address from `jdo[ADDR_W+1:2]`.
  - `jdo[35]=1` also requests a read at that address.
  - `jdo[36]=1` clears `monitor_error`.
- `take_action_ocimem_b` in 1: one-cycle strobe. Writes `jdo[34:3]` to the JTAG address, then post-increments the address.
- `take_no_action_ocimem_a` in 1: one-cycle strobe. Reads the JTAG address, then post-increments the address.
- `avs_address` in ADDR_W: CPU word address.
- `avs_read` in 1: CPU read request.
- `avs_write` in 1: CPU write request.
- `avs_writedata` in 32: CPU write data.
- `avs_byteenable` in 4: CPU byte enables.
- `avs_debugaccess` in 1: CPU writes take effect only when this is 1.
- `avs_readdata` out 32: CPU read data, registered.
- `avs_waitrequest` out 1: Avalon stall, combinational.
- `MonDReg` out 32: last JTAG read data.
- `monitor_ready` out 1: the last JTAG request has completed.
- `monitor_error` out 1: sticky JTAG overrun/collision flag.

## Operation
- **Request capture.** A JTAG strobe sets a one-entry pending register holding the kind (RD/WR), address and data, and clears `monitor_ready`.
  - Strobe priority: `a` > `b` > `no_action_a`.
  - More than one strobe in the same cycle: the highest-priority strobe is taken and `monitor_error` is set.
  - A strobe while a request is still pending or in flight: the strobe is discarded, `monitor_error` is set, and the JTAG address is unchanged.
- **FSM states:** IDLE, J_RD, C_RD.
- **IDLE, JTAG pending (JTAG has priority):**
  - WR: write the RAM (all bytes), increment the address, set `monitor_ready`, stay in IDLE.
  - RD: issue the RAM read and go to J_RD.
- **IDLE, no JTAG pending:**
  - `avs_write`: write with `avs_byteenable` if `avs_debugaccess`; otherwise drop the write silently. The write completes this cycle.
  - Else `avs_read`: issue the RAM read and go to C_RD.
- **J_RD:** load RAM q into `MonDReg`, set `monitor_ready`, increment the address (for `no_action_a` reads only), go to IDLE.
- **C_RD:** load RAM q into `avs_readdata`, go to IDLE.
- **`avs_waitrequest`** = (`avs_read` | `avs_write`) & ~(CPU access completing this cycle).
  - It is low in C_RD, and low in IDLE for an accepted write.
  - It is high whenever JTAG holds the port.
  - The CPU holds its request stable while stalled (Avalon rule).
- **Address arithmetic:** ADDR_W bits; `2^ADDR_W-1` wraps to 0.
- **Reset** (asynchronous, any state):
  - FSM → IDLE; pending cleared.
  - `MonDReg`=0, `avs_readdata`=0, `monitor_ready`=0, `monitor_error`=0, JTAG address=0.
  - RAM contents are unaffected.
  - A CPU request in progress at reset is re-served from IDLE after release.

## Timing
- JTAG strobe at edge N → pending at N.
- JTAG write: RAM written at edge N+1; `monitor_ready`=1 from N+1.
- JTAG read: read issued at N+1; `MonDReg` valid and `monitor_ready`=1 from N+2.
- CPU write with no contention: zero wait states.
- CPU read: one wait state; `avs_readdata` valid at the edge where waitrequest is low.
- JTAG contention adds 1 cycle (JTAG write) or 2 cycles (JTAG read) of CPU stall.
- A CPU read already in C_RD completes before JTAG is served.

## Structure
- Shared package/include holds:
  - FSM state encodings.
  - `jdo` field positions (address LSB, data [34:3], read flag 35, error-clear 36).
  - Pending-kind encodings.
- Sub-module `reverb_template_nios2_cpu_debug_mem_ram`: single-port, 1-cycle registered-read RAM with byte enables and `ADDR_W` parameter. Inferable; no reset.

## Test plan
- **JTAG write/read round trip.** Inputs:
  - `take_action_ocimem_a` with address 0x10, `jdo[35]`=0.
  - `take_action_ocimem_b` with data 0xDEADBEEF.
  - `take_action_ocimem_a` with address 0x10, `jdo[35]`=1.

  Expected: `MonDReg`=0xDEADBEEF, `monitor_ready` high at N+2.
- **Wrap.** Address 0xFF, then two `take_action_ocimem_b` writes (A, B). Expected: word 0xFF=A, word 0x00=B; reading via two `no_action_a` returns A then B.
- **Overrun.** Second strobe one cycle after the first. Expected: `monitor_error`=1, second request has no effect. `take_action_ocimem_a` with `jdo[36]`=1 then clears the error.
- **Contention.** CPU read of 0x20 held asserted in the same cycle as a JTAG read strobe. Expected: JTAG served first, CPU `avs_waitrequest` high for 3 cycles, then `avs_readdata` = RAM[0x20].
- **Write gating.** CPU write 0x12345678 with `avs_byteenable`=4'b0011 and `avs_debugaccess`=1 onto 0xFFFFFFFF → word becomes 0xFFFF5678. The same write with `avs_debugaccess`=0 leaves the word unchanged, with zero wait states.
- **Reset mid-read.** `reset_n` low in J_RD. Expected: all outputs 0, FSM in IDLE, no pending request, RAM contents retained.
